// File: rtl/ahb_mem_responder.sv
// Word-addressed AHB-style memory responder with fixed wait states and saturating transfer counters.
// Define MEM_ERR_RESP_EN to give out-of-range addresses a two-cycle ERROR response instead of aliasing.
`timescale 1ns/1ps
module ahb_mem_responder #(
    parameter int ADDR_BITS   = 12,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [31:0] hwdata,
    output logic [31:0] hrdata,
    output logic        hready,
    output logic        hresp,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA
`ifdef MEM_ERR_RESP_EN
        , S_ERR1,
        S_ERR2
`endif
    } state_t;

    state_t                 state;
    logic [31:0]            mem [2**ADDR_BITS];
    logic [ADDR_BITS-1:0]   addr_q;
    logic                   wr_q;
    logic [3:0]             cnt;
    logic                   accept;
    logic                   data_cyc;
    logic [ADDR_BITS-1:0]   idx;
    logic [31:0]            rd_fwd;

    assign accept   = hready && (htrans == 2'b10);
    assign data_cyc = (state == S_DATA);
    assign idx      = haddr[ADDR_BITS-1:0];

    // A zero-wait read accepted while a write to the same word closes must see that write's data.
    assign rd_fwd = (data_cyc && wr_q && (addr_q == idx)) ? hwdata : mem[idx];

`ifdef MEM_ERR_RESP_EN
    logic in_range;
    assign in_range = (haddr[31:ADDR_BITS] == '0);
`else
    logic unused_hi;
    assign unused_hi = |haddr[31:ADDR_BITS];
    assign hresp     = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            hready   <= 1'b1;
            hrdata   <= 32'h0;
            rd_count <= 16'h0;
            wr_count <= 16'h0;
            addr_q   <= '0;
            wr_q     <= 1'b0;
            cnt      <= 4'd0;
`ifdef MEM_ERR_RESP_EN
            hresp    <= 1'b0;
`endif
        end else begin
`ifdef MEM_ERR_RESP_EN
            hresp <= 1'b0;
`endif
            if (data_cyc) begin
                if (wr_q && wr_count != 16'hFFFF)  wr_count <= wr_count + 16'd1;
                if (!wr_q && rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
            end
            case (state)
                S_WAIT: begin
                    if (cnt == 4'd1) begin
                        state  <= S_DATA;
                        hready <= 1'b1;
                        if (!wr_q) hrdata <= mem[addr_q];
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
`ifdef MEM_ERR_RESP_EN
                S_ERR1: begin
                    state  <= S_ERR2;
                    hready <= 1'b1;
                    hresp  <= 1'b1;
                end
`endif
                default: begin
                    // IDLE, DATA and ERR2 all present hready=1 and may accept a new address.
                    if (accept) begin
                        addr_q <= idx;
                        wr_q   <= hwrite;
`ifdef MEM_ERR_RESP_EN
                        if (!in_range) begin
                            state  <= S_ERR1;
                            hready <= 1'b0;
                            hresp  <= 1'b1;
                        end else
`endif
                        if (WAIT_STATES > 0) begin
                            state  <= S_WAIT;
                            cnt    <= 4'(WAIT_STATES);
                            hready <= 1'b0;
                        end else begin
                            state  <= S_DATA;
                            hready <= 1'b1;
                            if (!hwrite) hrdata <= rd_fwd;
                        end
                    end else begin
                        state  <= S_IDLE;
                        hready <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Storage is deliberately not reset; the write lands at the edge closing the data phase.
    always_ff @(posedge clk) begin
        if (data_cyc && wr_q) mem[addr_q] <= hwdata;
    end

endmodule

// File: tb/tb_ahb_mem_responder.sv
// Randomised and directed bench for ahb_mem_responder: one instance with one wait state, one with none.
`timescale 1ns/1ps
module tb_ahb_mem_responder;

    localparam int WS = 1;

    logic tb_clk = 1'b0;
    logic rst;
    always #5 tb_clk = ~tb_clk;

    logic [31:0] haddr, hwdata, hrdata;
    logic [1:0]  htrans;
    logic        hwrite, hready, hresp;
    logic [15:0] rd_count, wr_count;

    logic [31:0] haddr0, hwdata0, hrdata0;
    logic [1:0]  htrans0;
    logic        hwrite0, hready0, hresp0;
    logic [15:0] rd_count0, wr_count0;

    ahb_mem_responder #(.ADDR_BITS(12), .WAIT_STATES(WS)) dut (
        .clk(tb_clk), .rst(rst), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
        .hwdata(hwdata), .hrdata(hrdata), .hready(hready), .hresp(hresp),
        .rd_count(rd_count), .wr_count(wr_count)
    );

    ahb_mem_responder #(.ADDR_BITS(12), .WAIT_STATES(0)) dut0 (
        .clk(tb_clk), .rst(rst), .haddr(haddr0), .htrans(htrans0), .hwrite(hwrite0),
        .hwdata(hwdata0), .hrdata(hrdata0), .hready(hready0), .hresp(hresp0),
        .rd_count(rd_count0), .wr_count(wr_count0)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: word store keyed by aliased index, plus saturating counts.
    logic [31:0] ref_mem [int];
    int ref_rd = 0, ref_wr = 0;
    int ref_rd0 = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > 32'hFFFF) ? 32'hFFFF : v;
    endfunction

    // One isolated transfer on the wait-state instance, checked against the model.
    task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data);
        int n;
        int key;
        key = int'(addr[11:0]);
        @(negedge tb_clk);
        haddr = addr; htrans = 2'b10; hwrite = wr; hwdata = 32'hBAD0_0000;
        chk("addr_phase_ready", {31'b0, hready}, 32'd1);
        @(negedge tb_clk);
        htrans = 2'b00; haddr = $urandom; hwrite = 1'($urandom);
        n = 0;
        while (hready !== 1'b1 && n < 20) begin
            n++;
            @(negedge tb_clk);
        end
        chk("wait_cycles", 32'(n), 32'(WS));
        if (wr) begin
            hwdata = data;
            ref_mem[key] = data;
            ref_wr = sat(ref_wr + 1);
        end else begin
            if (ref_mem.exists(key)) chk("read_data", hrdata, ref_mem[key]);
            ref_rd = sat(ref_rd + 1);
        end
        @(negedge tb_clk);
        hwdata = $urandom;
        chk("post_ready", {31'b0, hready}, 32'd1);
        chk("wr_count", {16'b0, wr_count}, 32'(ref_wr));
        chk("rd_count", {16'b0, rd_count}, 32'(ref_rd));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a, d;
        bit w;
        rst = 1'b1;
        haddr = 0; htrans = 0; hwrite = 0; hwdata = 0;
        haddr0 = 0; htrans0 = 0; hwrite0 = 0; hwdata0 = 0;
        #3;
        chk("rst_hready", {31'b0, hready}, 32'd1);
        chk("rst_hresp", {31'b0, hresp}, 32'd0);
        chk("rst_hrdata", hrdata, 32'h0);
        chk("rst_counts", {rd_count, wr_count}, 32'h0);
        chk("rst0_counts", {rd_count0, wr_count0}, 32'h0);
        @(negedge tb_clk); @(negedge tb_clk);
        rst = 1'b0;

        // Reset in the middle of a write's wait state must abort it.
        xfer(1'b1, 32'd5, 32'h1111_1111);
        @(negedge tb_clk);
        haddr = 32'd5; htrans = 2'b10; hwrite = 1'b1;
        @(negedge tb_clk);
        htrans = 2'b00; hwdata = 32'hDEAD_BEEF;
        chk("mid_wait_hready", {31'b0, hready}, 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_hready", {31'b0, hready}, 32'd1);
        chk("async_rst_hresp", {31'b0, hresp}, 32'd0);
        chk("async_rst_counts", {rd_count, wr_count}, 32'h0);
        ref_rd = 0; ref_wr = 0;
        @(negedge tb_clk);
        rst = 1'b0;
        xfer(1'b0, 32'd5, 32'h0);

        xfer(1'b1, 32'd3, 32'hA5A5_0001);
        xfer(1'b0, 32'd3, 32'h0);

        // Out-of-range access at 32'h1000.
`ifdef MEM_ERR_RESP_EN
        @(negedge tb_clk);
        haddr = 32'h0000_1000; htrans = 2'b10; hwrite = 1'b1;
        @(negedge tb_clk);
        htrans = 2'b00;
        chk("err1", {30'b0, hready, hresp}, 32'b01);
        @(negedge tb_clk);
        chk("err2", {30'b0, hready, hresp}, 32'b11);
        @(negedge tb_clk);
        chk("err_done", {30'b0, hready, hresp}, 32'b10);
        chk("err_counts", {rd_count, wr_count}, {16'(ref_rd), 16'(ref_wr)});
`else
        xfer(1'b1, 32'h0000_1000, 32'h0BAD_F00D);
        xfer(1'b0, 32'h0000_0000, 32'h0);
`endif

        for (int i = 0; i < 30; i++) begin
            w = 1'($urandom);
            a = 32'($urandom_range(0, 15));
`ifndef MEM_ERR_RESP_EN
            if ($urandom_range(0, 3) == 0) a = a | (32'h1000 * 32'($urandom_range(1, 7)));
`endif
            d = $urandom;
            xfer(w, a, d);
        end

        // Non-NONSEQ codes on the zero-wait instance must be ignored.
        for (int i = 0; i < 8; i++) begin
            @(negedge tb_clk);
            htrans0 = (i % 2 == 0) ? 2'b00 : 2'b11;
            haddr0 = $urandom; hwrite0 = 1'($urandom); hwdata0 = $urandom;
            chk("idle_hready0", {31'b0, hready0}, 32'd1);
            chk("idle_counts0", {rd_count0, wr_count0}, 32'h0);
        end
        @(negedge tb_clk);
        htrans0 = 2'b00;
        chk("idle_hrdata0", hrdata0, 32'h0);
        chk("idle_final_counts0", {rd_count0, wr_count0}, 32'h0);

        // Back-to-back write then read of the same word, zero wait states.
        @(negedge tb_clk);
        haddr0 = 32'd7; htrans0 = 2'b10; hwrite0 = 1'b1; hwdata0 = 32'hFFFF_0000;
        @(negedge tb_clk);
        chk("b2b_wdata_ready0", {31'b0, hready0}, 32'd1);
        hwdata0 = 32'h1234_5678; haddr0 = 32'd7; hwrite0 = 1'b0; htrans0 = 2'b10;
        @(negedge tb_clk);
        htrans0 = 2'b00; hwdata0 = 32'h0;
        chk("b2b_rdata_ready0", {31'b0, hready0}, 32'd1);
        chk("b2b_rdata0", hrdata0, 32'h1234_5678);
        @(negedge tb_clk);
        ref_rd0 = 1;
        chk("b2b_counts0", {rd_count0, wr_count0}, {16'd1, 16'd1});

        // Stream reads to drive rd_count into saturation.
        @(negedge tb_clk);
        haddr0 = 32'd7; hwrite0 = 1'b0; htrans0 = 2'b10;
        repeat (32'hFFFE - ref_rd0) @(negedge tb_clk);
        htrans0 = 2'b00;
        @(negedge tb_clk);
        ref_rd0 = sat(32'hFFFE);
        chk("sat_near0", {16'b0, rd_count0}, 32'(ref_rd0));
        chk("sat_hrdata0", hrdata0, 32'h1234_5678);
        htrans0 = 2'b10;
        repeat (3) @(negedge tb_clk);
        htrans0 = 2'b00;
        @(negedge tb_clk);
        ref_rd0 = sat(ref_rd0 + 3);
        chk("sat_hold0", {16'b0, rd_count0}, 32'(ref_rd0));
        chk("sat_wr0", {16'b0, wr_count0}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb_mem_responder.md
# ahb_mem_responder

Word-addressed AHB-style memory responder that sits on the far end of the edge-detection wrapper's master port. It serves the wrapper's pixel reads (greyscale input fetch) and result writes (buffer2 output store). Each transfer gets a fixed, parameterised number of wait states, and an optional error response for out-of-range addresses. It is the memory model used by block and system benches, and it is also synthesisable as on-chip frame SRAM.

## Interface
- ADDR_BITS, 12: memory depth is 2**ADDR_BITS 32-bit words.
- WAIT_STATES, 1: number of hready-low cycles per data phase (0..15).
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- haddr  in  32  word address; captured in the address phase.
- htrans  in  2  2'b10 NONSEQ = valid transfer; 2'b00 IDLE. Other codes are treated as IDLE.
- hwrite  in  1  1 = write, 0 = read; captured with haddr.
- hwdata  in  32  write data; sampled in the final data-phase cycle.
- hrdata  out  32  read data; valid when hready=1 in a read data phase.
- hready  out  1  1 = data phase completes this cycle, and a new address phase may be accepted.
- hresp  out  1  1 = ERROR response (only with MEM_ERR_RESP_EN).
- rd_count  out  16  completed reads; saturates at 16'hFFFF.
- wr_count  out  16  completed writes; saturates at 16'hFFFF.

## Operation
- Address phase: accepted on a rising edge where hready=1 and htrans=2'b10. haddr and hwrite are latched.
- While hready=0, haddr, htrans and hwrite are ignored.
- Address is in range when haddr[31:ADDR_BITS]==0.
- FSM states:
  - IDLE: hready=1.
  - WAIT: counter runs from WAIT_STATES down to 1, with hready=0.
  - DATA: final data-phase cycle, hready=1.
  - ERR1: hready=0, hresp=1.
  - ERR2: hready=1, hresp=1.
- Transitions:
  - IDLE/DATA go to WAIT on an accepted transfer when WAIT_STATES>0; otherwise straight to DATA.
  - WAIT goes to DATA when the counter reaches 1.
  - DATA with no new transfer goes to IDLE.
  - With MEM_ERR_RESP_EN, an out-of-range accept goes to ERR1, then ERR2, then IDLE (or to a new transfer accepted in ERR2).
- Read: mem[addr] appears on hrdata in the DATA cycle. hrdata holds its last value otherwise.
- Write: mem[addr] <= hwdata at the edge closing the DATA cycle.
- Read-after-write to the same address in back-to-back transfers returns the new data. With WAIT_STATES=0 this requires forwarding hwdata.
- Counters increment at the edge closing DATA. Error transfers do not count.
- Memory contents are not reset.

## Timing
- Reset values: hready=1, hresp=0, hrdata=32'h0, rd_count=0, wr_count=0, FSM=IDLE.
- Latency: with address accepted at edge N, data completes at edge N+1+WAIT_STATES.
- Throughput: one transfer per 1+WAIT_STATES cycles. Back-to-back transfers are pipelined: the next address is accepted in the DATA cycle of the previous one.
- WAIT_STATES=0: hready stays 1 continuously and no WAIT state is entered.
- Reset asserted mid-transfer: the transfer is aborted, the pending write is not performed, and outputs return to reset values asynchronously.
- Address wrap (without MEM_ERR_RESP_EN): the index is haddr[ADDR_BITS-1:0], so out-of-range addresses alias.
- Counter saturation: at 16'hFFFF the count holds and never wraps to 0.

## Configuration
- MEM_ERR_RESP_EN defined:
  - Out-of-range transfers get the two-cycle ERROR response (ERR1, ERR2).
  - No memory write occurs and hrdata is unchanged.
- MEM_ERR_RESP_EN undefined:
  - hresp is tied to 0 and the ERR states are absent.
  - Out-of-range addresses alias modulo depth and complete normally.

## Test plan
- Reset check: assert rst mid-WAIT of a write to addr 5 with hwdata=32'hDEADBEEF. Require hready=1, hresp=0, counters=0 immediately. A following read of addr 5 must not return 32'hDEADBEEF.
- Single write/read (WAIT_STATES=1):
  - Write 32'hA5A5_0001 to addr 3: hready is low 1 cycle, high at N+2, wr_count=1.
  - Read addr 3: hrdata=32'hA5A5_0001 at N+2, rd_count=1.
- Back-to-back with WAIT_STATES=0: write addr 7 = 32'h1234_5678 followed immediately by read addr 7. hrdata=32'h1234_5678 in the next cycle, and hready stays 1 throughout.
- Out-of-range access: access haddr=32'h0000_1000 (ADDR_BITS=12).
  - With MEM_ERR_RESP_EN: hresp=1 for 2 cycles with hready 0 then 1, and counters unchanged.
  - Without it: write aliases to addr 0, and a read of addr 0 returns the written data.
- htrans=2'b00 and 2'b11 with haddr toggling: no state change, hready stays 1, counters stay 0.
- Saturation: preload the counters via 65,536 reads. rd_count stays at 16'hFFFF after read 65,536.
